rr_mux_nx1: RTL and testbench

//   Registered N-to-1 data multiplexer with round-robin arbitration and valid/ready handshake.

---
 rtl/rr_mux_nx1.sv | 116 +++++++++++
 tb/tb_rr_mux_nx1.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_nx1.sv
// rr_mux_nx1 : registered N-to-1 mux with round-robin arbitration and a
// valid/ready handshake on both sides. The output register holds a single
// entry and has no skid buffer, so a new word can only be accepted on a
// cycle when that register is empty or is being popped.
// Optional feature macro RR_MUX_SEL_EN adds sel_force/sel, which bypass
// the arbiter and grant only the channel named by sel.
module rr_mux_nx1 #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_CH    = 4,
    localparam int CHW      = $clog2(NUM_CH)
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    output logic [NUM_CH-1:0]           in_ready,
    output logic [DATAWIDTH-1:0]        out_data,
    output logic [CHW-1:0]              out_ch,
    output logic                        out_valid,
`ifdef RR_MUX_SEL_EN
    input  logic                        sel_force,
    input  logic [CHW-1:0]              sel,
`endif
    input  logic                        out_ready
);

    logic [CHW-1:0]       ptr_q, ptr_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [CHW-1:0]       ch_q, ch_d;
    logic                 valid_q, valid_d;

    logic                 load;
    logic                 gnt_any;
    logic [CHW-1:0]       gnt_idx;
    logic                 forced;
    logic                 take;

    assign load = !valid_q || out_ready;

    // Arbiter: first requesting channel at or after ptr, wrapping modulo NUM_CH.
    // The forced path compares sel against every legal index so that an
    // out-of-range sel simply matches nothing.
    always_comb begin
        int k;
        k       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        forced  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NUM_CH) k = k - NUM_CH;
            if (!gnt_any && in_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = CHW'(k);
            end
        end
`ifdef RR_MUX_SEL_EN
        if (sel_force) begin
            forced  = 1'b1;
            gnt_any = 1'b0;
            gnt_idx = sel;
            for (int j = 0; j < NUM_CH; j++) begin
                if (sel == CHW'(j) && in_valid[j]) gnt_any = 1'b1;
            end
        end
`endif
    end

    assign take = load && gnt_any && !Rst;

    // One-hot accept toward the producers; never asserted during reset.
    always_comb begin
        in_ready = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            in_ready[j] = take && (gnt_idx == CHW'(j));
        end
    end

    // Next-state for output register and rr pointer.
    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (take) begin
            data_d  = in_data[int'(gnt_idx)*DATAWIDTH +: DATAWIDTH];
            ch_d    = gnt_idx;
            valid_d = 1'b1;
            if (!forced) begin
                ptr_d = (gnt_idx == CHW'(NUM_CH-1)) ? '0 : gnt_idx + CHW'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_nx1.sv
// tb_rr_mux_nx1 : directed bench for rr_mux_nx1 with a 4-channel and a
// 3-channel instance; expected values are hand-computed per step.
module tb_rr_mux_nx1;

    logic        Clk = 1'b0;
    logic        Rst, rst3;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid, out_ready;
`ifdef RR_MUX_SEL_EN
    logic        sel_force;
    logic [1:0]  sel;
`endif

    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3, out_ready3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    rr_mux_nx1 #(.DATAWIDTH(8), .NUM_CH(4)) u_dut4 (
        .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid),
`ifdef RR_MUX_SEL_EN
        .sel_force(sel_force), .sel(sel),
`endif
        .out_ready(out_ready)
    );

    rr_mux_nx1 #(.DATAWIDTH(8), .NUM_CH(3)) u_dut3 (
        .Clk(Clk), .Rst(rst3), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_ch(out_ch3),
        .out_valid(out_valid3),
`ifdef RR_MUX_SEL_EN
        .sel_force(1'b0), .sel(2'd0),
`endif
        .out_ready(out_ready3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst        = 1'b1;
        rst3       = 1'b1;
        in_data    = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid   = 4'hF;
        out_ready  = 1'b1;
        in_data3   = {8'hA2, 8'hA1, 8'hA0};
        in_valid3  = 3'b000;
        out_ready3 = 1'b1;
`ifdef RR_MUX_SEL_EN
        sel_force  = 1'b0;
        sel        = 2'd0;
`endif
        #1;
        check("rst_in_ready", in_ready, 4'h0);
        tick();
        check("rst_in_ready2", in_ready, 4'h0);
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        Rst  = 1'b0;
        rst3 = 1'b0;

        // All channels requesting, consumer always ready: 0,1,2,3,0,1,2
        for (int i = 0; i < 7; i++) begin
            #1;
            check("rr_in_ready", in_ready, 32'(4'b0001 << (i % 4)));
            tick();
            check("rr_out_ch", out_ch, i % 4);
            check("rr_out_data", out_data, 8'h11 * ((i % 4) + 1));
            check("rr_out_valid", out_valid, 1);
        end

        // Stall with ch2 held
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", in_ready, 4'h0);
            tick();
            check("stall_out_ch", out_ch, 2);
            check("stall_out_data", out_data, 8'h33);
            check("stall_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 4'b1000);
        tick();
        check("release_out_ch", out_ch, 3);
        check("release_out_data", out_data, 8'h44);

        // Drain: no requests, word popped; data/ch retained
        in_valid = 4'h0;
        #1;
        check("drain_in_ready", in_ready, 4'h0);
        tick();
        check("drain_out_valid", out_valid, 0);
        check("drain_out_ch", out_ch, 3);
        check("drain_out_data", out_data, 8'h44);

        // Single requester granted every cycle
        in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("single_in_ready", in_ready, 4'b0100);
            tick();
            check("single_out_ch", out_ch, 2);
            check("single_out_valid", out_valid, 1);
        end

        // ptr=3 now: grants 3 then 0, leaving ptr=1 before reset
        in_valid = 4'hF;
        tick();
        check("pre_rst_ch3", out_ch, 3);
        tick();
        check("pre_rst_ch0", out_ch, 0);
        Rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 4'h0);
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        Rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 4'b0001);
        tick();
        check("post_rst_out_ch", out_ch, 0);
        check("post_rst_out_valid", out_valid, 1);

`ifdef RR_MUX_SEL_EN
        Rst = 1'b1;
        tick();
        Rst       = 1'b0;
        sel_force = 1'b1;
        sel       = 2'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("force_in_ready", in_ready, 4'b1000);
            tick();
            check("force_out_ch", out_ch, 3);
        end
        sel_force = 1'b0;
        #1;
        check("force_ptr_kept", in_ready, 4'b0001);
        tick();
        sel_force = 1'b1;
        in_valid  = 4'b0111;
        #1;
        check("force_novalid_ready", in_ready, 4'h0);
        tick();
        check("force_novalid_valid", out_valid, 0);
        sel_force = 1'b0;
`endif

        // 3-channel instance: wrap and skip on a non-power-of-2 count
        in_valid3 = 3'b010;
        #1;
        check("n3_first_ready", in_ready3, 3'b010);
        tick();
        check("n3_first_ch", out_ch3, 1);
        in_valid3 = 3'b011;
        #1;
        check("n3_skip_ready", in_ready3, 3'b001);
        tick();
        check("n3_skip_ch", out_ch3, 0);
        check("n3_skip_data", out_data3, 8'hA0);
        #1;
        check("n3_next_ready", in_ready3, 3'b010);
        tick();
        check("n3_next_ch", out_ch3, 1);
        in_valid3 = 3'b100;
        #1;
        check("n3_last_ready", in_ready3, 3'b100);
        tick();
        check("n3_last_ch", out_ch3, 2);
        in_valid3 = 3'b111;
        #1;
        check("n3_wrap_ready", in_ready3, 3'b001);
        tick();
        check("n3_wrap_ch", out_ch3, 0);
        check("n3_wrap_valid", out_valid3, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
